// File: rtl/multichannel_averager_pkg.sv
// multichannel_averager_pkg
//   Shared definitions for the multichannel averager:
//   - mode_e           : averaging mode encodings (block / sliding)
//   - rounding_offset  : constant added before the final >> M shift
package multichannel_averager_pkg;

  typedef enum logic {
    MODE_BLOCK   = 1'b0,
    MODE_SLIDING = 1'b1
  } mode_e;

  // Half of one LSB of the result (2^(m-1)) when rounding is enabled,
  // otherwise zero so the shift simply truncates.
  function automatic int rounding_offset(input int m, input int rnd_en);
    if (rnd_en != 0 && m > 0) begin
      return 1 << (m - 1);
    end
    return 0;
  endfunction

endpackage

// File: rtl/multichannel_averager_avg_channel.sv
// avg_channel
//   Datapath for one channel: N+M bit accumulator, 2^M-entry history
//   ring (used in sliding mode) and the registered N-bit average.
//   Ports:
//     cclk, rstb     clock / synchronous active-low reset
//     accept         sample on raw is consumed this edge
//     clear          drop accumulator contents (mode change)
//     ptr            shared history ring index
//     last_in_block  this sample completes a window (block: counter wrap,
//                    sliding: ring becomes full)
//     fill_done      ring already full before this sample, so hist[ptr]
//                    holds a live sample that leaves the window now
//     mode_q         registered mode
//     raw            channel sample
//     averaged       registered average
module avg_channel
  import multichannel_averager_pkg::*;
#(
  parameter int N     = 8,
  parameter int M     = 2,
  parameter int ROUND = 0
) (
  input  logic         cclk,
  input  logic         rstb,
  input  logic         accept,
  input  logic         clear,
  input  logic [M-1:0] ptr,
  input  logic         last_in_block,
  input  logic         fill_done,
  input  mode_e        mode_q,
  input  logic [N-1:0] raw,
  output logic [N-1:0] averaged
);

  localparam int W = N + M;
  localparam logic [W:0] RND = (W + 1)'(rounding_offset(M, ROUND));

  logic [N-1:0] hist_mem [2**M];
  logic [W-1:0] acc_reg, acc_next;
  logic [W-1:0] hist_rd;
  logic [W-1:0] acc_sum;
  logic [W:0]   rnd_sum;
  logic [N-1:0] averaged_reg, averaged_next;
  logic         sliding;

  assign sliding = (mode_q == MODE_SLIDING);

  always_comb begin
    // Entries not written since the last clear are exactly the ones the
    // pointer has not yet wrapped onto, so they read as zero until full.
    hist_rd = '0;
    if (sliding && fill_done) begin
      hist_rd = {{M{1'b0}}, hist_mem[ptr]};
    end
    // Wrap-around in the subtraction is harmless: the true window sum
    // always fits in W bits.
    acc_sum = acc_reg + {{M{1'b0}}, raw} - hist_rd;
    rnd_sum = {1'b0, acc_sum} + RND;

    acc_next      = acc_reg;
    averaged_next = averaged_reg;
    if (clear) begin
      acc_next = '0;
    end else if (accept) begin
      if (sliding) begin
        acc_next = acc_sum;
        if (last_in_block || fill_done) begin
          averaged_next = rnd_sum[M +: N];
        end
      end else if (last_in_block) begin
        acc_next      = '0;
        averaged_next = rnd_sum[M +: N];
      end else begin
        acc_next = acc_sum;
      end
    end
  end

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      acc_reg      <= '0;
      averaged_reg <= '0;
    end else begin
      acc_reg      <= acc_next;
      averaged_reg <= averaged_next;
    end
  end

  // History ring has no reset; its stale contents are masked by fill_done.
  always_ff @(posedge cclk) begin
    if (rstb && !clear && accept && sliding) begin
      hist_mem[ptr] <= raw;
    end
  end

  assign averaged = averaged_reg;

endmodule

// File: rtl/multichannel_averager.sv
// multichannel_averager
//   Averages C unsigned N-bit channels over a 2^M-sample window in
//   block (decimating) or sliding (boxcar) mode, with optional
//   round-half-up.
//   Ports:
//     cclk      clock, rising edge
//     rstb      synchronous active-low reset
//     ena       sample strobe
//     mode      0 = block, 1 = sliding (a change restarts averaging)
//     raw       packed samples, channel k at [k*N +: N]
//     averaged  packed registered averages, same packing
//     valid     one-cycle strobe: averaged updated on this edge
module multichannel_averager
  import multichannel_averager_pkg::*;
#(
  parameter int N     = 8,
  parameter int M     = 2,
  parameter int C     = 2,
  parameter int ROUND = 0
) (
  input  logic           cclk,
  input  logic           rstb,
  input  logic           ena,
  input  logic           mode,
  input  logic [C*N-1:0] raw,
  output logic [C*N-1:0] averaged,
  output logic           valid
);

  localparam logic [M:0]   FILL_FULL = (M + 1)'(2**M);
  localparam logic [M:0]   FILL_LAST = (M + 1)'(2**M - 1);
  localparam logic [M-1:0] CNT_LAST  = '1;

  mode_e        mode_q_reg;
  mode_e        mode_in;
  logic [M-1:0] cnt_reg;
  logic [M-1:0] ptr_reg;
  logic [M:0]   fill_reg;
  logic         valid_reg, valid_next;
  logic         clear, accept, sliding, fill_done, last_in_block;

  assign mode_in   = mode_e'(mode);
  // A mode change spends its edge on clearing; the sample is dropped.
  assign clear     = (mode_in != mode_q_reg);
  assign accept    = ena && !clear;
  assign sliding   = (mode_q_reg == MODE_SLIDING);
  assign fill_done = (fill_reg == FILL_FULL);
  assign last_in_block = sliding ? (fill_reg == FILL_LAST)
                                 : (cnt_reg == CNT_LAST);
  assign valid_next = accept && (last_in_block || (sliding && fill_done));

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      mode_q_reg <= MODE_BLOCK;
      cnt_reg    <= '0;
      ptr_reg    <= '0;
      fill_reg   <= '0;
      valid_reg  <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      if (clear) begin
        mode_q_reg <= mode_in;
        cnt_reg    <= '0;
        ptr_reg    <= '0;
        fill_reg   <= '0;
      end else if (accept) begin
        if (sliding) begin
          ptr_reg <= ptr_reg + 1'b1;
          if (!fill_done) begin
            fill_reg <= fill_reg + 1'b1;
          end
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < C; gi++) begin : g_chan
      avg_channel #(
        .N     (N),
        .M     (M),
        .ROUND (ROUND)
      ) u_chan (
        .cclk          (cclk),
        .rstb          (rstb),
        .accept        (accept),
        .clear         (clear),
        .ptr           (ptr_reg),
        .last_in_block (last_in_block),
        .fill_done     (fill_done),
        .mode_q        (mode_q_reg),
        .raw           (raw[gi*N +: N]),
        .averaged      (averaged[gi*N +: N])
      );
    end
  endgenerate

  assign valid = valid_reg;

endmodule

// File: doc/multichannel_averager.md
Name: multichannel_averager

Overview:
- Parametrised successor to the single-channel power-of-two averager in the debugger datapath.
- Averages C independent unsigned N-bit channels over a 2^M-sample window.
- Two modes: block/decimating (one result per window) and sliding/boxcar (one result per sample after warm-up).
- Selectable truncate or round-half-up; explicit result-valid strobe for downstream capture/display logic.

Parameters:
- N, 8, sample width per channel (unsigned).
- M, 2, log2 of window length; legal range 1..8.
- C, 2, number of channels.
- ROUND, 0, 0 = truncate, 1 = round-half-up (add 2^(M-1) before shifting).

Ports:
- cclk  in  1  clock; all state updates on rising edge.
- rstb  in  1  synchronous active-low reset.
- ena  in  1  sample strobe; raw is consumed only on cycles with ena=1.
- mode  in  1  0 = block, 1 = sliding; sampled every cycle.
- raw  in  C*N  packed samples; channel k occupies bits [k*N+N-1 : k*N].
- averaged  out  C*N  packed registered averages, same packing as raw.
- valid  out  1  one-cycle strobe; averaged was updated on this edge.

Behaviour:
- Reset (rstb=0 at a clock edge): averaged=0, valid=0, all accumulators=0, sample counter=0, history pointer=0, fill count=0, mode_q=0. Reset mid-window discards the partial window.
- Accumulator width is N+M per channel, so no overflow is possible. Result = (acc + rnd) >> M, where rnd = ROUND ? 2^(M-1) : 0. The rounding sum is computed at N+M+1 bits; the result always fits in N bits (max input yields max output).
- ena=0: all state holds; valid=0; averaged holds.
- Mode change: mode is registered as mode_q. If mode != mode_q at an edge, that edge only clears accumulators, counter, pointer and fill count, and updates mode_q. The sample is ignored even if ena=1; valid=0; averaged holds. Operation in the new mode starts on the next edge.
- Block mode (mode_q=0):
  - Per accepted sample: acc += raw; counter += 1 (M bits, wraps).
  - On the sample with counter = 2^M-1: averaged <= (acc + raw + rnd) >> M; acc <= 0; valid=1 on that edge.
  - Latency: result visible 1 cycle after the last sample of the window. Exactly one valid per 2^M accepted samples.
- Sliding mode (mode_q=1):
  - Each channel owns a 2^M-entry history ring, written at ptr.
  - Per accepted sample: acc <= acc + raw - hist[ptr] (hist entries count as 0 until written since the last clear); hist[ptr] <= raw; ptr += 1 (wraps).
  - fill count saturates at 2^M.
  - Once the current sample brings fill to 2^M, every accepted sample yields averaged <= (new acc + rnd) >> M and valid=1.
  - No valid during warm-up (first 2^M-1 samples).
- All channels share counter, pointer, fill and valid; the channels differ only in data.
- The history is register-based or inferred RAM. The read of hist[ptr] must be same-cycle (read before write).

Decomposition:
- Package multichannel_averager_pkg: mode encodings (MODE_BLOCK=0, MODE_SLIDING=1); function rounding_offset(M, ROUND).
- Sub-module avg_channel (parameters N, M, ROUND): one channel's accumulator, history ring and output register. It is driven by shared control (accept, clear, ptr, last_in_block, fill_done, mode_q) from the top-level control logic, instantiated C times in a generate loop.

Test Plan:
- N=8, M=2, C=2, ROUND=0, block mode: ch0 = 1,2,3,4; ch1 = 10,20,30,40 → after the 4th sample, averaged ch0=2, ch1=25, valid high exactly 1 cycle; no valid on samples 1–3.
- Same stimulus, ROUND=1 → ch0=3 ((10+2)>>2); ch1=25 ((100+2)>>2).
- Block mode, ch0 = 255 ×4 with ena gaps (ena=0 for 3 cycles between samples) → averaged ch0=255, single valid. Gaps change nothing; averaged holds during gaps.
- Sliding mode, ROUND=0, ch0 = 4,8,12,16,20,24 → no valid for samples 1–3; then averaged = 10, 14, 18 with valid on each.
- Mode switch and reset mid-operation:
  - In block mode, feed 2 samples, then toggle mode with ena=1 → no valid on the switch edge; that sample is dropped; the sliding warm-up restarts (4 more samples before the first valid).
  - Pull rstb=0 mid-window → averaged=0, valid=0; the next window starts from an empty accumulator.
